// File: rtl/display_pkg.sv
// Shared constants for the multiplexed 7-segment display: digit count,
// segment bit order and the hex glyph table (active-high).
package display_pkg;

    localparam int NUM_DIGITS = 8;

    // Bit position of each segment on the 7-bit segment bus, {g,f,e,d,c,b,a}.
    typedef enum logic [2:0] {
        SEG_A, SEG_B, SEG_C, SEG_D, SEG_E, SEG_F, SEG_G
    } seg_bit_e;

    localparam int SEG_W = int'(SEG_G) + 1;

    // Entry n lights the glyph for hex digit n; leftmost entry is index 15.
    localparam logic [15:0][SEG_W-1:0] SEG_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational hex nibble to 7-segment glyph decoder (active-high segments).
module hex_to_7seg
    import display_pkg::*;
(
    input  logic [3:0]       nibble,
    output logic [SEG_W-1:0] seg
);

    assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/hexdisplay_driver.sv
// Time-multiplexed 8-digit hex display driver with frame-synchronous
// snapshot of the input word, leading-zero blanking and anti-ghost dead slot.
module hexdisplay_driver
    import display_pkg::*;
#(
    parameter int SCAN_DIV = 50000,
    parameter int BLANK_LZ = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] din,
    input  logic                    en,
    output logic [NUM_DIGITS-1:0]   an_n,
    output logic [SEG_W-1:0]        seg_n,
    output logic                    dp_n,
    output logic                    frame_tick
);

    localparam int CNT_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W  = $clog2(NUM_DIGITS);
    localparam int DATA_W = 4 * NUM_DIGITS;

    logic [CNT_W-1:0]  cnt;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] shadow;
    logic [DATA_W-1:0] upper;
    logic [3:0]        nibble;
    logic [SEG_W-1:0]  seg;
    logic              cnt_wrap;
    logic              frame_load;
    logic              blank;
    logic              dark;

    always_comb begin
        cnt_wrap   = (cnt == CNT_W'(SCAN_DIV - 1));
        frame_load = cnt_wrap && (idx == IDX_W'(NUM_DIGITS - 1));
        // Nibbles idx..7 shifted down; zero means this and all higher digits are zero.
        upper      = shadow >> {idx, 2'b00};
        nibble     = upper[3:0];
        blank      = (BLANK_LZ != 0) && (idx != '0) && (upper == '0);
        dark       = (cnt == '0) || !en || blank;
    end

    hex_to_7seg u_hex_to_7seg (
        .nibble (nibble),
        .seg    (seg)
    );

    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            idx        <= '0;
            shadow     <= '0;
            an_n       <= '1;
            seg_n      <= '1;
            frame_tick <= 1'b0;
        end else begin
            cnt        <= cnt_wrap ? '0 : cnt + 1'b1;
            if (cnt_wrap) begin
                idx <= idx + 1'b1;
            end
            // Snapshot only at the frame boundary so a frame never mixes two words.
            if (frame_load) begin
                shadow <= din;
            end
            frame_tick <= frame_load;
            an_n       <= dark ? '1 : ~(NUM_DIGITS'(1) << idx);
            seg_n      <= dark ? '1 : ~seg;
        end
    end

    assign dp_n = 1'b1;

endmodule

// File: tb/tb_hexdisplay_driver.sv
// Directed self-checking bench for hexdisplay_driver with SCAN_DIV=4; a second
// instance with leading-zero blanking disabled shares the same inputs.
module tb_hexdisplay_driver;

    logic        clk;
    logic        rst_n;
    logic [31:0] din;
    logic        en;
    logic [7:0]  an_n;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic        frame_tick;
    logic [7:0]  an_n_nb;
    logic [6:0]  seg_n_nb;
    logic        dp_n_nb;
    logic        frame_tick_nb;

    int checks = 0;
    int errors = 0;
    int k      = 0;   // rising edges since the latest reset release

    hexdisplay_driver #(.SCAN_DIV(4), .BLANK_LZ(1)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .en         (en),
        .an_n       (an_n),
        .seg_n      (seg_n),
        .dp_n       (dp_n),
        .frame_tick (frame_tick)
    );

    hexdisplay_driver #(.SCAN_DIV(4), .BLANK_LZ(0)) u_dut_nb (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .en         (en),
        .an_n       (an_n_nb),
        .seg_n      (seg_n_nb),
        .dp_n       (dp_n_nb),
        .frame_tick (frame_tick_nb)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to the falling edge after rising edge number 'target'.
    task automatic to_k(input int target);
        while (k < target) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic check_disp(input string tag, input logic [7:0] an_exp, input logic [6:0] seg_exp);
        check({tag, ".an_n"}, {24'h0, an_n}, {24'h0, an_exp});
        check({tag, ".seg_n"}, {25'h0, seg_n}, {25'h0, seg_exp});
    endtask

    task automatic check_disp_nb(input string tag, input logic [7:0] an_exp, input logic [6:0] seg_exp);
        check({tag, ".an_n_nb"}, {24'h0, an_n_nb}, {24'h0, an_exp});
        check({tag, ".seg_n_nb"}, {25'h0, seg_n_nb}, {25'h0, seg_exp});
    endtask

    initial begin
        din   = 32'h0;
        en    = 1'b1;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check_disp("rst_async", 8'hFF, 7'h7F);
        check("rst_async.dp_n", {31'h0, dp_n}, 32'h1);
        check("rst_async.tick", {31'h0, frame_tick}, 32'h0);
        repeat (2) @(negedge clk);
        check_disp("rst_held", 8'hFF, 7'h7F);
        rst_n = 1'b1;
        k     = 0;

        // Before the first frame boundary the cleared snapshot shows a lone "0".
        to_k(1);
        check_disp("dead_slot0", 8'hFF, 7'h7F);
        check("pre_tick", {31'h0, frame_tick}, 32'h0);
        to_k(2);
        check_disp("zero_d0", 8'hFE, 7'h40);
        check_disp_nb("zero_d0", 8'hFE, 7'h40);
        to_k(6);
        check_disp("zero_d1_blank", 8'hFF, 7'h7F);
        check_disp_nb("zero_d1_noblank", 8'hFD, 7'h40);
        to_k(30);
        check_disp("zero_d7_blank", 8'hFF, 7'h7F);
        check_disp_nb("zero_d7_noblank", 8'h7F, 7'h40);

        din = 32'h0000_00A5;
        to_k(31);
        check("tick1_before", {31'h0, frame_tick}, 32'h0);
        to_k(32);
        check("tick1", {31'h0, frame_tick}, 32'h1);
        check("dp_n", {31'h0, dp_n}, 32'h1);
        to_k(33);
        check("tick1_after", {31'h0, frame_tick}, 32'h0);
        to_k(34);
        check_disp("a5_d0", 8'hFE, 7'h12);
        to_k(38);
        check_disp("a5_d1", 8'hFD, 7'h08);
        check_disp_nb("a5_d1", 8'hFD, 7'h08);
        to_k(42);
        check_disp("a5_d2_blank", 8'hFF, 7'h7F);
        check_disp_nb("a5_d2_noblank", 8'hFB, 7'h40);
        to_k(62);
        check_disp("a5_d7_blank", 8'hFF, 7'h7F);

        // New word mid-frame must not appear until the following boundary.
        din = 32'h1234_5678;
        to_k(64);
        check("tick2", {31'h0, frame_tick}, 32'h1);
        to_k(66);
        check_disp("w1_d0", 8'hFE, 7'h00);
        to_k(70);
        din = 32'hFFFF_FFFF;
        to_k(78);
        check_disp("w1_d3_hold", 8'hF7, 7'h12);
        to_k(94);
        check_disp("w1_d7_hold", 8'h7F, 7'h79);
        to_k(95);
        check("tick3_before", {31'h0, frame_tick}, 32'h0);
        check_disp("w1_d7_last", 8'h7F, 7'h79);
        to_k(96);
        check("tick3", {31'h0, frame_tick}, 32'h1);
        to_k(98);
        check_disp("wf_d0", 8'hFE, 7'h0E);

        // Disable across a frame boundary; scan and ticks keep running.
        to_k(122);
        en = 1'b0;
        to_k(124);
        check_disp("en0_a", 8'hFF, 7'h7F);
        to_k(128);
        check("tick_en0", {31'h0, frame_tick}, 32'h1);
        check_disp("en0_b", 8'hFF, 7'h7F);
        to_k(131);
        check_disp("en0_c", 8'hFF, 7'h7F);
        to_k(132);
        en = 1'b1;
        to_k(134);
        check_disp("en1_d1", 8'hFD, 7'h0E);

        // Reset in the middle of digit 5 (cnt=2, idx=5).
        to_k(150);
        check_disp("pre_rst_d5", 8'hDF, 7'h0E);
        #1 rst_n = 1'b0;
        #1;
        check_disp("rst_mid", 8'hFF, 7'h7F);
        check("rst_mid.tick", {31'h0, frame_tick}, 32'h0);
        check("rst_mid.dp_n", {31'h0, dp_n}, 32'h1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        k     = 0;
        to_k(2);
        check_disp("rst2_zero_d0", 8'hFE, 7'h40);
        to_k(31);
        check("rst2_tick_before", {31'h0, frame_tick}, 32'h0);
        to_k(32);
        check("rst2_tick", {31'h0, frame_tick}, 32'h1);
        to_k(34);
        check_disp("rst2_wf_d0", 8'hFE, 7'h0E);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hexdisplay_driver.md
HEXDISPLAY_DRIVER -- requirements
Module: hexdisplay_driver

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000, meaning clock cycles per digit slot; legal range is >= 2.
REQ-002 SHALL have parameter BLANK_LZ, default 1, meaning leading-zero blanking is enabled when 1.
REQ-003 SHALL have port clk  input  1  meaning the single system clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  meaning reset, asynchronous and active-low.
REQ-005 SHALL have port din  input  32  meaning the GPIO output word written by the CPU, displayed as 8 hex nibbles.
REQ-006 SHALL have port en  input  1  meaning display enable; when 0 all digits are dark.
REQ-007 SHALL have port an_n  output  8  meaning active-low digit enables; bit i selects nibble din[4i+3:4i].
REQ-008 SHALL have port seg_n  output  7  meaning active-low segments, ordered {g,f,e,d,c,b,a}.
REQ-009 SHALL have port dp_n  output  1  meaning active-low decimal point; it is held at 1.
REQ-010 SHALL have port frame_tick  output  1  meaning a one-cycle pulse in the cycle after a new snapshot is loaded.

Function
REQ-011 SHALL keep a prescaler cnt counting 0..SCAN_DIV-1 and wrapping to 0; it runs regardless of en.
REQ-012 SHALL keep a 3-bit digit index idx that increments modulo 8 on each cnt wrap (cnt==SCAN_DIV-1).
REQ-013 SHALL load a 32-bit shadow register from din only when cnt==SCAN_DIV-1 and idx==7, i.e. at the frame boundary.
REQ-014 SHALL ignore changes on din between frame boundaries, so no frame mixes nibbles of two words.
REQ-015 SHALL assert frame_tick for exactly one cycle in the cycle after each shadow load; period = 8*SCAN_DIV cycles.
REQ-016 SHALL register an_n and seg_n, giving one cycle of latency from (cnt, idx, shadow, en).
REQ-017 SHALL drive an_n = 8'hFF for the dead slot cnt==0 of every digit (anti-ghosting), when en==0, or when the digit is blanked.
REQ-018 SHALL otherwise drive an_n with only bit idx low.
REQ-019 SHALL decode nibble shadow[4*idx+3:4*idx] with the active-high patterns 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 B:7C C:39 D:5E E:79 F:71, and drive seg_n with the bitwise inverse.
REQ-020 SHALL blank digit i>0 when BLANK_LZ==1 and nibbles i..7 of shadow are all zero; digit 0 is never blanked.
REQ-021 SHALL drive seg_n = 7'h7F whenever an_n==8'hFF.
REQ-022 SHALL not restart cnt, idx or shadow on an en transition; display resumes in the current slot.

Reset
REQ-023 SHALL while rst_n==0 immediately force cnt=0, idx=0, shadow=0, an_n=8'hFF, seg_n=7'h7F, dp_n=1, frame_tick=0.
REQ-024 SHALL abandon a frame that is in progress when reset is asserted; after release the first load occurs at cycle 8*SCAN_DIV.
REQ-025 SHALL display shadow=0 (digit 0 showing "0") until the first frame boundary after reset.

Structure
REQ-026 SHALL take NUM_DIGITS=8, the segment bit-order definition and the 16-entry segment pattern table from shared package display_pkg.
REQ-027 SHALL implement nibble decoding in one combinational sub-module hex_to_7seg (4-bit in, 7-bit active-high out), instantiated once.

Verification (SCAN_DIV=4)
REQ-028 SHALL verify reset: with rst_n=0 at any cycle, an_n=FF, seg_n=7F, dp_n=1 and frame_tick=0 in that same cycle.
REQ-029 SHALL verify that with din=32'h0000_00A5 after the first tick, slot 0 gives an_n=FE, seg_n=12 and slot 1 gives an_n=FD, seg_n=08, while digits 2-7 stay dark.
REQ-030 SHALL verify that changing din from 32'h1234_5678 to 32'hFFFF_FFFF mid-frame shows only the 1234_5678 digits until the next frame_tick, with ticks 32 cycles apart.
REQ-031 SHALL verify that with din=0 only digit 0 lights (an_n=FE, seg_n=40), and that with BLANK_LZ=0 all eight digits show seg_n=40.
REQ-032 SHALL verify that en=0 for 10 cycles holds an_n=FF and seg_n=7F, frame_tick continues, and re-enable shows the digit matching the free-running idx.
REQ-033 SHALL verify that asserting rst_n=0 at cnt=2, idx=5 clears outputs asynchronously and that the first tick after release arrives 32 cycles later.
